voice_allocator: RTL and testbench

//  Polyphony scheduler between the USB keyboard HID report and the N-voice synth datapath.
//  On each new 6-slot keycode report: releases voices whose key is no longer held,

---
 rtl/synth_pkg.sv | 22 ++
 rtl/key_note_map.sv | 33 +++
 rtl/voice_allocator.sv | 221 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the keyboard-to-synth voice allocation path.
//   keycode_t      : one HID usage code
//   KEY_NONE       : empty report slot
//   KEY_ROLLOVER   : HID phantom/rollover marker; the whole report is invalid
//   INC_W_DEFAULT  : default phase-increment width
//   alloc_state_t  : voice allocator sequencing states
package synth_pkg;

    typedef logic [7:0] keycode_t;

    localparam keycode_t    KEY_NONE      = 8'h00;
    localparam keycode_t    KEY_ROLLOVER  = 8'h01;
    localparam int unsigned INC_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RELEASE,
        ALLOC,
        DONE
    } alloc_state_t;

endpackage

// File: rtl/key_note_map.sv
// Combinational HID keycode -> oscillator phase increment.
// The home row plays a chromatic scale starting at A; every other key maps to 0
// (unmapped), which the allocator treats as "ignore this key".
//   keycode : HID usage code
//   inc     : phase increment, 0 when the key has no note
module key_note_map
    import synth_pkg::*;
#(
    parameter int unsigned INC_W = INC_W_DEFAULT
) (
    input  logic [7:0]       keycode,
    output logic [INC_W-1:0] inc
);

    logic [15:0] base;

    always_comb begin
        case (keycode)
            8'h04:   base = 16'h022A; // A
            8'h16:   base = 16'h024B; // S
            8'h07:   base = 16'h026E; // D
            8'h09:   base = 16'h0293; // F
            8'h0A:   base = 16'h02BA; // G
            8'h0B:   base = 16'h02E4; // H
            8'h0D:   base = 16'h0310; // J
            8'h0E:   base = 16'h033F; // K
            8'h0F:   base = 16'h0370; // L
            default: base = 16'h0000;
        endcase
        inc = INC_W'(base);
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: turns 6-slot HID keyboard reports into per-voice note state.
// Each accepted report is walked twice: one voice per cycle to release voices whose
// key is gone, then one slot per cycle to hand new keys to free voices (stealing the
// oldest voice when none is free). A single key_note_map is shared by all slots.
//   Clk, Reset      : clock, synchronous active-high reset
//   report_valid    : strobe, report_keys carries a new report
//   report_keys     : slot s in bits [8s+7:8s]
//   voice_active    : voice v sounding
//   voice_keycode   : keycode owned by voice v (8 bits per voice)
//   voice_inc       : phase increment of voice v (INC_W bits per voice)
//   voice_on/off    : one-cycle trigger / release pulses per voice
//   busy            : a report is being processed
//   update_done     : one-cycle pulse when a report has been fully applied
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NUM_SLOTS  = 6,
    parameter int unsigned INC_W      = INC_W_DEFAULT,
    parameter int unsigned AGE_W      = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        report_valid,
    input  logic [8*NUM_SLOTS-1:0]      report_keys,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [8*NUM_VOICES-1:0]     voice_keycode,
    output logic [INC_W*NUM_VOICES-1:0] voice_inc,
    output logic [NUM_VOICES-1:0]       voice_on,
    output logic [NUM_VOICES-1:0]       voice_off,
    output logic                        busy,
    output logic                        update_done
);

    localparam int unsigned     MAX_N   = (NUM_SLOTS > NUM_VOICES) ? NUM_SLOTS : NUM_VOICES;
    localparam int unsigned     IDX_W   = $clog2(MAX_N);
    localparam int unsigned     VID_W   = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    alloc_state_t           state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   pending_q;
    logic [8*NUM_SLOTS-1:0] held_q;
    keycode_t               snap_q [NUM_SLOTS];
    keycode_t               key_q  [NUM_VOICES];
    logic [INC_W-1:0]       inc_q  [NUM_VOICES];
    logic [AGE_W-1:0]       age_q  [NUM_VOICES];

    logic [8*NUM_SLOTS-1:0] in_keys;
    logic                   in_rollover;
    keycode_t               slot_key;
    logic [INC_W-1:0]       slot_inc;
    logic                   slot_owned;
    logic                   slot_dup;
    logic                   slot_take;
    logic                   rel_hit;
    logic                   free_found;
    logic [VID_W-1:0]       free_idx;
    logic [VID_W-1:0]       old_idx;
    logic [AGE_W-1:0]       old_age;
    logic [VID_W-1:0]       tgt_idx;

    // A fresh strobe in IDLE is newer than anything held, so it takes priority.
    assign in_keys = report_valid ? report_keys : held_q;
    assign busy    = (state_q != IDLE);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign voice_keycode[8*v +: 8]     = key_q[v];
        assign voice_inc[INC_W*v +: INC_W] = inc_q[v];
    end

    key_note_map #(
        .INC_W (INC_W)
    ) u_key_note_map (
        .keycode (slot_key),
        .inc     (slot_inc)
    );

    always_comb begin
        in_rollover = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (in_keys[8*s +: 8] == KEY_ROLLOVER) in_rollover = 1'b1;
        end
    end

    // Slot under consideration in ALLOC; mux by loop to keep index widths exact.
    always_comb begin
        slot_key = KEY_NONE;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (idx_q == IDX_W'(s)) slot_key = snap_q[s];
        end
    end

    always_comb begin
        slot_dup = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if ((IDX_W'(s) < idx_q) && (snap_q[s] == slot_key)) slot_dup = 1'b1;
        end
        slot_owned = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_active[v] && (key_q[v] == slot_key)) slot_owned = 1'b1;
        end
        slot_take = (slot_key != KEY_NONE) && (slot_inc != '0) && !slot_owned && !slot_dup;
    end

    // Voice under consideration in RELEASE: active and its key missing from the snapshot.
    always_comb begin
        rel_hit = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if ((idx_q == IDX_W'(v)) && voice_active[v]) begin
                rel_hit = 1'b1;
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (snap_q[s] == key_q[v]) rel_hit = 1'b0;
                end
            end
        end
    end

    // Lowest free voice wins; otherwise the oldest (strict > keeps ties on lowest index).
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active[v]) begin
                free_found = 1'b1;
                free_idx   = VID_W'(v);
            end
        end
        old_idx = '0;
        old_age = age_q[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > old_age) begin
                old_age = age_q[v];
                old_idx = VID_W'(v);
            end
        end
        tgt_idx = free_found ? free_idx : old_idx;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            held_q       <= '0;
            voice_active <= '0;
            voice_on     <= '0;
            voice_off    <= '0;
            update_done  <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) snap_q[s] <= KEY_NONE;
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_q[v] <= KEY_NONE;
                inc_q[v] <= '0;
                age_q[v] <= '0;
            end
        end else begin
            voice_on    <= '0;
            voice_off   <= '0;
            update_done <= 1'b0;

            if (report_valid && (state_q != IDLE)) begin
                pending_q <= 1'b1;
                held_q    <= report_keys;
            end

            unique case (state_q)
                IDLE: begin
                    if (report_valid || pending_q) begin
                        pending_q <= 1'b0;
                        if (!in_rollover) begin
                            for (int s = 0; s < NUM_SLOTS; s++) snap_q[s] <= in_keys[8*s +: 8];
                            idx_q   <= '0;
                            state_q <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (rel_hit && (idx_q == IDX_W'(v))) begin
                            voice_active[v] <= 1'b0;
                            voice_off[v]    <= 1'b1;
                            age_q[v]        <= '0;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                        idx_q   <= '0;
                        state_q <= ALLOC;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ALLOC: begin
                    if (slot_take) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (tgt_idx == VID_W'(v)) begin
                                key_q[v]        <= slot_key;
                                inc_q[v]        <= slot_inc;
                                voice_active[v] <= 1'b1;
                                age_q[v]        <= '0;
                                voice_on[v]     <= 1'b1;
                            end else if (voice_active[v] && (age_q[v] != AGE_MAX)) begin
                                age_q[v] <= age_q[v] + 1'b1;
                            end
                        end
                    end
                    if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    update_done <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        report_valid;
    logic [47:0] report_keys;
    logic [3:0]  voice_active;
    logic [31:0] voice_keycode;
    logic [63:0] voice_inc;
    logic [3:0]  voice_on;
    logic [3:0]  voice_off;
    logic        busy;
    logic        update_done;

    always #5 Clk = ~Clk;

    voice_allocator #(
        .NUM_VOICES (4),
        .NUM_SLOTS  (6),
        .INC_W      (16),
        .AGE_W      (4)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .report_valid  (report_valid),
        .report_keys   (report_keys),
        .voice_active  (voice_active),
        .voice_keycode (voice_keycode),
        .voice_inc     (voice_inc),
        .voice_on      (voice_on),
        .voice_off     (voice_off),
        .busy          (busy),
        .update_done   (update_done)
    );

    typedef struct {
        logic [3:0]  active;
        logic [31:0] keys;
        logic [63:0] incs;
        logic [3:0]  on;
        logic [3:0]  off;
        int          lat;
    } exp_t;

    exp_t       sb [$];
    int         checks   = 0;
    int         failures = 0;
    int         lat;
    logic [3:0] on_acc;
    logic [3:0] off_acc;
    logic       both_seen;
    logic       done_seen;
    logic       activity;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_push(input logic [3:0] a, input logic [31:0] k, input logic [63:0] i,
                               input logic [3:0] on, input logic [3:0] off, input int l);
        exp_t e;
        e.active = a;
        e.keys   = k;
        e.incs   = i;
        e.on     = on;
        e.off    = off;
        e.lat    = l;
        sb.push_back(e);
    endtask

    task automatic drive_report(input logic [47:0] keys);
        report_keys  = keys;
        report_valid = 1'b1;
        @(negedge Clk);
        report_valid = 1'b0;
    endtask

    // Waits (bounded) for update_done, collecting pulses; optionally fires two
    // back-to-back reports while the DUT is busy.
    task automatic wait_done(input logic inject, input logic [47:0] ka, input logic [47:0] kb);
        lat       = 0;
        on_acc    = '0;
        off_acc   = '0;
        both_seen = 1'b0;
        done_seen = 1'b0;
        while (!done_seen && lat < 40) begin
            @(negedge Clk);
            lat++;
            on_acc  |= voice_on;
            off_acc |= voice_off;
            if ((voice_on & voice_off) != 4'b0) both_seen = 1'b1;
            if (update_done) done_seen = 1'b1;
            if (inject) begin
                if (lat == 2) begin
                    report_keys  = ka;
                    report_valid = 1'b1;
                end else if (lat == 3) begin
                    report_keys = kb;
                end else if (lat == 4) begin
                    report_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic score(input string tag);
        exp_t e;
        check({tag, ".done"}, 64'(done_seen), 64'd1);
        check({tag, ".queued"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".latency"}, 64'(lat), 64'(e.lat));
            check({tag, ".active"}, 64'(voice_active), 64'(e.active));
            check({tag, ".keycode"}, 64'(voice_keycode), 64'(e.keys));
            check({tag, ".inc"}, voice_inc, e.incs);
            check({tag, ".on"}, 64'(on_acc), 64'(e.on));
            check({tag, ".off"}, 64'(off_acc), 64'(e.off));
            check({tag, ".on_off_same_cycle"}, 64'(both_seen), 64'd0);
        end
    endtask

    task automatic watch_quiet(input int n);
        activity = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (busy || update_done || (voice_on != 4'b0) || (voice_off != 4'b0)) activity = 1'b1;
        end
    endtask

    initial begin
        Reset        = 1'b1;
        report_valid = 1'b0;
        report_keys  = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset.active", 64'(voice_active), 64'd0);
        check("reset.keycode", 64'(voice_keycode), 64'd0);
        check("reset.inc", voice_inc, 64'd0);
        check("reset.pulses", 64'({voice_on, voice_off}), 64'd0);
        check("reset.busy_done", 64'({busy, update_done}), 64'd0);

        // {A}: first voice, done 11 cycles after sampling.
        expect_push(4'b0001, 32'h0000_0004, 64'h0000_0000_0000_022A, 4'b0001, 4'b0000, 11);
        drive_report(48'h0000_0000_0004);
        wait_done(1'b0, '0, '0);
        score("r1_a");

        // {A,S}: only S is new.
        expect_push(4'b0011, 32'h0000_1604, 64'h0000_0000_024B_022A, 4'b0010, 4'b0000, 11);
        drive_report(48'h0000_0000_1604);
        wait_done(1'b0, '0, '0);
        score("r2_as");

        // {A,S,D,F}: fills voices 2 and 3; ages become 3,2,1,0.
        expect_push(4'b1111, 32'h0907_1604, 64'h0293_026E_024B_022A, 4'b1100, 4'b0000, 11);
        drive_report(48'h0000_0907_1604);
        wait_done(1'b0, '0, '0);
        score("r3_asdf");

        // {S,D,F,G}: A released from voice 0, G lands there; ages v1..v3 = 3,2,1.
        expect_push(4'b1111, 32'h0907_160A, 64'h0293_026E_024B_02BA, 4'b0001, 4'b0001, 11);
        drive_report(48'h0000_0A09_0716);
        wait_done(1'b0, '0, '0);
        score("r4_release");

        // {S,D,F,G,H}: full, H steals oldest voice 1 without an off pulse.
        expect_push(4'b1111, 32'h0907_0B0A, 64'h0293_026E_02E4_02BA, 4'b0010, 4'b0000, 11);
        drive_report(48'h000B_0A09_0716);
        wait_done(1'b0, '0, '0);
        score("r5_steal");

        // Rollover marker: the whole report is ignored.
        drive_report(48'h0000_0000_0116);
        watch_quiet(20);
        check("rollover.activity", 64'(activity), 64'd0);
        check("rollover.active", 64'(voice_active), 64'hF);
        check("rollover.keycode", 64'(voice_keycode), 64'h0907_0B0A);

        // {Z,A,A}: all released, unmapped Z skipped, duplicate A allocated once.
        expect_push(4'b0001, 32'h0907_0B04, 64'h0293_026E_02E4_022A, 4'b0001, 4'b1111, 11);
        drive_report(48'h0000_0004_041D);
        wait_done(1'b0, '0, '0);
        score("r7_unmapped_dup");

        // {S} then {D},{F} while busy: only {F} follows, starting right after done.
        expect_push(4'b0001, 32'h0907_0B16, 64'h0293_026E_02E4_024B, 4'b0001, 4'b0001, 11);
        expect_push(4'b0001, 32'h0907_0B09, 64'h0293_026E_02E4_0293, 4'b0001, 4'b0001, 12);
        drive_report(48'h0000_0000_0016);
        wait_done(1'b1, 48'h0000_0000_0007, 48'h0000_0000_0009);
        score("r8_first");
        wait_done(1'b0, '0, '0);
        score("r8_pending");
        watch_quiet(20);
        check("pending.extra", 64'(activity), 64'd0);
        check("scoreboard.drained", 64'(sb.size()), 64'd0);

        // {D,F} with a pending report queued, then reset in the middle of ALLOC.
        drive_report(48'h0000_0000_0907);
        repeat (3) @(negedge Clk);
        report_keys  = 48'h0000_0000_000B;
        report_valid = 1'b1;
        @(negedge Clk);
        report_valid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midreset.active", 64'(voice_active), 64'd0);
        check("midreset.keycode", 64'(voice_keycode), 64'd0);
        check("midreset.inc", voice_inc, 64'd0);
        check("midreset.pulses", 64'({voice_on, voice_off, update_done}), 64'd0);
        check("midreset.busy", 64'(busy), 64'd0);
        watch_quiet(30);
        check("midreset.pending_lost", 64'(activity), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
